pixel_parallelizer: RTL
=======================

# pixel_parallelizer

Packs a one-pixel-per-beat AXI-Stream into bursts of PIXELS_PER_BURST pixels on a wide AXI-Stream. It is the transmit-side counterpart of the sequentializer, sitting where per-pixel processing results return to the wide CustomLogic datapath. Frame alignment comes from the start-of-frame user bit. Each output burst carries start-of-frame and end-of-frame markers.

## Interface
- PIXEL_BIT_WIDTH, 10, bits per pixel
- PIXELS_PER_BURST, 10, pixels packed per output beat
- USER_WIDTH, 2, width of tuser; bit0 = SOF, bit1 = EOF, higher bits driven 0
- IN_ROWS, 20, rows per frame
- IN_COLS, 20, columns per frame; IN_ROWS*IN_COLS must be a multiple of PIXELS_PER_BURST (elaboration-time check)
- clk  input  1  single clock
- s_axis_resetn  input  1  reset, asynchronous, active-low
- s_axis_tvalid  input  1  pixel valid
- s_axis_tready  output  1  pixel accepted
- s_axis_tdata  input  PIXEL_BIT_WIDTH  pixel
- s_axis_tuser  input  USER_WIDTH  bit0 = first pixel of frame
- m_axis_tvalid  output  1  burst valid
- m_axis_tready  input  1  downstream ready
- m_axis_tdata  output  PIXEL_BIT_WIDTH*PIXELS_PER_BURST  burst; pixel k at bits [k*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH]
- m_axis_tuser  output  USER_WIDTH  bit0 = first burst of frame, bit1 = last burst of frame
- resync_err  output  1  sticky; set when SOF arrives mid-frame

## Operation
- States: WAIT_SOF, PACK.
- WAIT_SOF: s_axis_tready=1. Beats without tuser[0] are discarded. A beat with tuser[0] is stored as pixel 0 of burst 0 (cnt_idx_in_burst=1, cnt_idx_in_frame=1) and the state moves to PACK.
- PACK: each accepted beat is written into slot cnt_idx_in_burst of the pack register, and both counters increment.
- Burst completion: on acceptance of slot PIXELS_PER_BURST-1, the full word (including this pixel) moves to the output register, and cnt_idx_in_burst wraps to 0.
  - The output word's tuser[0] is set if it is burst 0.
  - The output word's tuser[1] is set if cnt_idx_in_frame reaches IN_ROWS*IN_COLS.
- Frame end: the last burst has been moved to the output register, cnt_idx_in_frame clears, and the state returns to WAIT_SOF.
- Backpressure: s_axis_tready = 0 only when the pending beat would complete a burst AND the output register is occupied AND m_axis_tready=0. Otherwise s_axis_tready=1.
- Mid-frame SOF (tuser[0] on an accepted beat in PACK):
  - The partial burst is discarded.
  - The counters restart with this beat as pixel 0.
  - resync_err is set.
  - A burst already in the output register is still delivered, unchanged.
- Reset (asserted at any time, including mid-frame): asynchronously clears state to WAIT_SOF, both counters, the pack register and the output register.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, resync_err=0, s_axis_tready=0 while s_axis_resetn=0. s_axis_tready=1 from the first clk edge after deassertion.
- Latency: last pixel of a burst accepted at edge N → m_axis_tvalid=1 after edge N.
- Throughput: one pixel per cycle sustained when m_axis_tready=1, so bursts are spaced PIXELS_PER_BURST cycles apart.
- AXI rule: once m_axis_tvalid=1, m_axis_tdata and m_axis_tuser stay stable until the handshake.
- Simultaneous events:
  - An output handshake and a burst completion in the same cycle: the new burst replaces the old one with no bubble.
  - An SOF on the beat right after frame end is taken in WAIT_SOF with no lost beat.
- Counter widths: $clog2(PIXELS_PER_BURST) and $clog2(IN_ROWS*IN_COLS+1).

## Configuration
- PIXEL_PARALLELIZER_ASSERT_EN defined: SVA checks compile in. They cover:
  - output stability under backpressure;
  - tuser[0] and tuser[1] never both set when the frame has more than one burst;
  - for systematic bench data, pixel k of burst b equals b*PIXELS_PER_BURST+k.
- Undefined: no assertions, with identical RTL behaviour.

## Structure
- pixel_parallelizer_pkg holds:
  - the state enum (WAIT_SOF, PACK);
  - user-bit index constants SOF_BIT=0 and EOF_BIT=1.
- One sub-module, burst_out_reg: a single-entry output holding register with valid/ready and load/drain logic.

## Test plan
Bench configuration: W=10, PPB=10, IN_ROWS=4, IN_COLS=10.
- Wait-for-SOF: 3 pixels without SOF, then SOF plus pixels 0..39 with m_axis_tready=1 → exactly 4 bursts. Burst 0 tdata holds 0..9 (pixel 0 in the LSBs) with tuser=01. Burst 3 holds 30..39 with tuser=10.
- Backpressure: m_axis_tready=0 for 25 cycles mid-frame → s_axis_tready falls on the pixel completing the second pending burst. There is no loss or duplication, and burst data stays stable while stalled.
- Back-to-back frames: the SOF of frame 2 arrives the cycle after pixel 39 → 8 bursts in total with no stall cycle.
- Mid-frame SOF: SOF at pixel 15 → resync_err=1. The partial 10..14 is discarded. The next burst is 0..9 of the new frame with tuser=01.
- Async reset mid-burst (pixel 7): all outputs go to their reset values immediately. After reset release, the block waits for SOF and then produces correct bursts.
- Random m_axis_tready at 50% over 3 frames → output sequence matches the reference model.

Source files
------------

// File: rtl/pixel_parallelizer_pkg.sv
// Shared types and constants for the pixel_parallelizer block.
package pixel_parallelizer_pkg;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    PACK     = 1'b1
  } state_t;

  localparam int SOF_BIT = 0;
  localparam int EOF_BIT = 1;

endpackage

// File: rtl/pixel_parallelizer_burst_out_reg.sv
// Single-entry holding register for packed bursts, with valid/ready drain.
// A load always wins over a drain, so a completing burst can replace a departing one.
module burst_out_reg #(
  parameter int DATA_WIDTH = 100,
  parameter int USER_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [USER_WIDTH-1:0] load_user,
  input  logic                  ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic [USER_WIDTH-1:0] user
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid <= 1'b0;
      data  <= '0;
      user  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      user  <= load_user;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pixel_parallelizer.sv
// Packs a one-pixel-per-beat stream into PIXELS_PER_BURST-wide bursts aligned to SOF.
// Define PIXEL_PARALLELIZER_ASSERT_EN to compile in the SVA checks.
module pixel_parallelizer
  import pixel_parallelizer_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH  = 10,
  parameter int PIXELS_PER_BURST = 10,
  parameter int USER_WIDTH       = 2,
  parameter int IN_ROWS          = 20,
  parameter int IN_COLS          = 20
) (
  input  logic                                     clk,
  input  logic                                     s_axis_resetn,
  input  logic                                     s_axis_tvalid,
  output logic                                     s_axis_tready,
  input  logic [PIXEL_BIT_WIDTH-1:0]               s_axis_tdata,
  input  logic [USER_WIDTH-1:0]                    s_axis_tuser,
  output logic                                     m_axis_tvalid,
  input  logic                                     m_axis_tready,
  output logic [PIXEL_BIT_WIDTH*PIXELS_PER_BURST-1:0] m_axis_tdata,
  output logic [USER_WIDTH-1:0]                    m_axis_tuser,
  output logic                                     resync_err
);

  localparam int TOTAL   = IN_ROWS * IN_COLS;
  localparam int PPB     = PIXELS_PER_BURST;
  localparam int W       = PIXEL_BIT_WIDTH;
  localparam int BURST_W = $clog2(PPB);
  localparam int FRAME_W = $clog2(TOTAL + 1);

  if ((TOTAL % PPB) != 0) begin : g_bad_geometry
    $error("IN_ROWS*IN_COLS must be a multiple of PIXELS_PER_BURST");
  end
  if (USER_WIDTH < 2 || PPB < 2) begin : g_bad_widths
    $error("USER_WIDTH must be >= 2 and PIXELS_PER_BURST >= 2");
  end

  state_t               state;
  logic [BURST_W-1:0]   cnt_idx_in_burst;
  logic [FRAME_W-1:0]   cnt_idx_in_frame;
  logic [W-1:0]         pack [PPB];
  logic                 rdy_en;

  logic                 accept;
  logic                 sof_in;
  logic                 last_slot;
  logic                 frame_last;
  logic                 first_burst;
  logic                 complete;
  logic [W*PPB-1:0]     word;
  logic [USER_WIDTH-1:0] word_user;

  assign sof_in      = s_axis_tuser[SOF_BIT];
  assign last_slot   = (state == PACK) && (cnt_idx_in_burst == BURST_W'(PPB - 1));
  assign frame_last  = (cnt_idx_in_frame == FRAME_W'(TOTAL - 1));
  assign first_burst = (cnt_idx_in_frame == FRAME_W'(PPB - 1));

  // Only a burst-completing beat can be blocked, and only when the output slot cannot free up.
  assign s_axis_tready = rdy_en && !(last_slot && m_axis_tvalid && !m_axis_tready);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign complete      = accept && last_slot && !sof_in;

  always_comb begin
    word = '0;
    for (int k = 0; k < PPB - 1; k++) begin
      word[k*W +: W] = pack[k];
    end
    word[(PPB-1)*W +: W] = s_axis_tdata;
    word_user          = '0;
    word_user[SOF_BIT] = first_burst;
    word_user[EOF_BIT] = frame_last;
  end

  always_ff @(posedge clk or negedge s_axis_resetn) begin
    if (!s_axis_resetn) begin
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge s_axis_resetn) begin
    if (!s_axis_resetn) begin
      state            <= WAIT_SOF;
      cnt_idx_in_burst <= '0;
      cnt_idx_in_frame <= '0;
      resync_err       <= 1'b0;
      for (int k = 0; k < PPB; k++) begin
        pack[k] <= '0;
      end
    end else if (accept) begin
      if (sof_in) begin
        // SOF always restarts the frame; mid-frame it drops the partial burst.
        pack[0]          <= s_axis_tdata;
        cnt_idx_in_burst <= BURST_W'(1);
        cnt_idx_in_frame <= FRAME_W'(1);
        state            <= PACK;
        if (state == PACK) begin
          resync_err <= 1'b1;
        end
      end else if (state == PACK) begin
        if (last_slot) begin
          cnt_idx_in_burst <= '0;
          if (frame_last) begin
            cnt_idx_in_frame <= '0;
            state            <= WAIT_SOF;
          end else begin
            cnt_idx_in_frame <= cnt_idx_in_frame + FRAME_W'(1);
          end
        end else begin
          pack[cnt_idx_in_burst] <= s_axis_tdata;
          cnt_idx_in_burst       <= cnt_idx_in_burst + BURST_W'(1);
          cnt_idx_in_frame       <= cnt_idx_in_frame + FRAME_W'(1);
        end
      end
    end
  end

  burst_out_reg #(
    .DATA_WIDTH(W * PPB),
    .USER_WIDTH(USER_WIDTH)
  ) u_out (
    .clk      (clk),
    .resetn   (s_axis_resetn),
    .load     (complete),
    .load_data(word),
    .load_user(word_user),
    .ready    (m_axis_tready),
    .valid    (m_axis_tvalid),
    .data     (m_axis_tdata),
    .user     (m_axis_tuser)
  );

`ifdef PIXEL_PARALLELIZER_ASSERT_EN
  logic               a_sys;
  logic [FRAME_W-1:0] a_bidx;

  // Systematic frames are recognised by their first burst starting 0,1.
  always_ff @(posedge clk or negedge s_axis_resetn) begin
    if (!s_axis_resetn) begin
      a_sys  <= 1'b0;
      a_bidx <= '0;
    end else if (m_axis_tvalid && m_axis_tready) begin
      if (m_axis_tuser[SOF_BIT]) begin
        a_sys  <= (m_axis_tdata[0 +: W] == W'(0)) && (m_axis_tdata[W +: W] == W'(1));
        a_bidx <= FRAME_W'(1);
      end else begin
        a_bidx <= a_bidx + FRAME_W'(1);
      end
    end
  end

  a_stable: assert property (@(posedge clk) disable iff (!s_axis_resetn)
    (m_axis_tvalid && !m_axis_tready) |=>
      (m_axis_tvalid && $stable(m_axis_tdata) && $stable(m_axis_tuser)));

  a_sof_eof: assert property (@(posedge clk) disable iff (!s_axis_resetn)
    (TOTAL > PPB && m_axis_tvalid) |->
      !(m_axis_tuser[SOF_BIT] && m_axis_tuser[EOF_BIT]));

  for (genvar k = 0; k < PPB; k++) begin : g_sys_chk
    a_sys_pixel: assert property (@(posedge clk) disable iff (!s_axis_resetn)
      (m_axis_tvalid && a_sys && !m_axis_tuser[SOF_BIT]) |->
        (m_axis_tdata[k*W +: W] == W'(int'(a_bidx) * PPB + k)));
  end
`endif

endmodule
